// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - two-requester RAM arbiter bus bundle
// Purpose: groups both requester ports and the RAM-side port of ram_arbiter.
// Signals:
//   req0/1, we0/1, addr0/1, wdata0/1, be0/1 : requester commands (held until ready)
//   ready0/1, rvalid0/1, rdata0/1           : per-port accept / read-return
//   ram_d, ram_ad, ram_we                   : arbiter to RAM
//   ram_q                                   : RAM registered read data
//   busy                                    : arbiter not in IDLE
// Modports: slave = arbiter side, master = requesters plus RAM side.
interface ram_arbiter_if #(
  parameter int WORD  = 4,
  parameter int WIDTH = 8
);
  localparam int DW = WORD * WIDTH;

  logic            req0;
  logic            req1;
  logic            we0;
  logic            we1;
  logic [DW-1:0]   addr0;
  logic [DW-1:0]   addr1;
  logic [DW-1:0]   wdata0;
  logic [DW-1:0]   wdata1;
  logic [WORD-1:0] be0;
  logic [WORD-1:0] be1;
  logic            ready0;
  logic            ready1;
  logic            rvalid0;
  logic            rvalid1;
  logic [DW-1:0]   rdata0;
  logic [DW-1:0]   rdata1;
  logic [DW-1:0]   ram_d;
  logic [DW-1:0]   ram_ad;
  logic            ram_we;
  logic [DW-1:0]   ram_q;
  logic            busy;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, be0, be1, ram_q,
    output ready0, ready1, rvalid0, rvalid1, rdata0, rdata1,
    output ram_d, ram_ad, ram_we, busy
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, be0, be1, ram_q,
    input  ready0, ready1, rvalid0, rvalid1, rdata0, rdata1,
    input  ram_d, ram_ad, ram_we, busy
  );
endinterface

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin two-port arbiter in front of a single-port RAM
// Purpose: shares one registered-read RAM between port 0 (CPU data) and
//   port 1 (loader/debug). Reads take one extra cycle (RD_WAIT), full-word
//   writes complete in the accept cycle, partial writes do read-modify-write
//   (RMW), and an all-zero byte enable write is acknowledged without touching RAM.
// Ports:
//   clk   : single clock, all state on rising edge
//   reset : synchronous, active-high
//   bus   : ram_arbiter_if.slave (requester ports, RAM port, busy)
module ram_arbiter #(
  parameter int WORD       = 4,
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic          clk,
  input  logic          reset,
  ram_arbiter_if.slave  bus
);
  localparam int DW = WORD * WIDTH;

  // ADDR_WIDTH only sizes the external RAM; the arbiter passes addresses through.
  if (ADDR_WIDTH < 1) begin : g_addr_width_unused
  end

  typedef enum logic [1:0] {IDLE, RD_WAIT, RMW} state_t;

  state_t          state, state_nx;
  logic            last_grant, last_grant_nx;
  logic            rd_port, rd_port_nx;
  logic            latch_en;
  logic [DW-1:0]   lat_addr;
  logic [DW-1:0]   lat_wdata;
  logic [WORD-1:0] lat_be;

  // Arbitration: a lone requester wins; on a tie the port not granted last wins.
  logic            win_valid;
  logic            win;
  logic            sel_we;
  logic [DW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic [WORD-1:0] sel_be;
  logic [DW-1:0]   merged;

  always_comb begin
    win_valid = bus.req0 | bus.req1;
    win       = (bus.req0 && bus.req1) ? ~last_grant : bus.req1;
    sel_we    = win ? bus.we1    : bus.we0;
    sel_addr  = win ? bus.addr1  : bus.addr0;
    sel_wdata = win ? bus.wdata1 : bus.wdata0;
    sel_be    = win ? bus.be1    : bus.be0;
  end

  // RMW merge: ram_q holds the old word read during the accept cycle.
  always_comb begin
    merged = bus.ram_q;
    for (int i = 0; i < WORD; i++) begin
      if (lat_be[i]) merged[i*WIDTH +: WIDTH] = lat_wdata[i*WIDTH +: WIDTH];
    end
  end

  assign bus.rdata0 = bus.ram_q;
  assign bus.rdata1 = bus.ram_q;

  always_comb begin
    state_nx      = state;
    last_grant_nx = last_grant;
    rd_port_nx    = rd_port;
    latch_en      = 1'b0;
    bus.ready0    = 1'b0;
    bus.ready1    = 1'b0;
    bus.rvalid0   = 1'b0;
    bus.rvalid1   = 1'b0;
    bus.ram_d     = '0;
    bus.ram_ad    = '0;
    bus.ram_we    = 1'b0;
    bus.busy      = 1'b0;
    // Reset masks every output, which also aborts an in-flight RD_WAIT/RMW.
    if (!reset) begin
      bus.busy = (state != IDLE);
      case (state)
        IDLE: begin
          if (win_valid) begin
            bus.ready0    = ~win;
            bus.ready1    = win;
            last_grant_nx = win;
            bus.ram_ad    = sel_addr;
            if (!sel_we) begin
              rd_port_nx = win;
              state_nx   = RD_WAIT;
            end else if (&sel_be) begin
              bus.ram_we = 1'b1;
              bus.ram_d  = sel_wdata;
            end else if (|sel_be) begin
              // Accept cycle doubles as the read of the old word.
              latch_en = 1'b1;
              state_nx = RMW;
            end
          end
        end
        RD_WAIT: begin
          bus.rvalid0 = ~rd_port;
          bus.rvalid1 = rd_port;
          state_nx    = IDLE;
        end
        RMW: begin
          bus.ram_ad = lat_addr;
          bus.ram_we = 1'b1;
          bus.ram_d  = merged;
          state_nx   = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      rd_port    <= 1'b0;
    end else begin
      state      <= state_nx;
      last_grant <= last_grant_nx;
      rd_port    <= rd_port_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (latch_en) begin
      lat_addr  <= sel_addr;
      lat_wdata <= sel_wdata;
      lat_be    <= sel_be;
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed self-checking bench for ram_arbiter
module tb_ram_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  ram_arbiter_if #(.WORD(4), .WIDTH(8)) bus ();

  ram_arbiter #(.WORD(4), .WIDTH(8), .ADDR_WIDTH(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Registered-read RAM: 256 words, byte address truncated to 10 bits.
  logic [31:0] mem [256];

  always @(posedge clk) begin
    bus.ram_q <= mem[bus.ram_ad[9:2]];
    if (bus.ram_we) mem[bus.ram_ad[9:2]] <= bus.ram_d;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  task automatic port0(input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata; bus.be0 = be;
  endtask

  task automatic port1(input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata; bus.be1 = be;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[4]    = 32'h1111_1111;
    mem[8]    = 32'h2222_2222;
    bus.ram_q = 32'h0;

    // Reset with both ports requesting.
    reset = 1'b1;
    port0(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    port1(1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_ready0", bus.ready0, 1'b0);
    chk("rst_ready1", bus.ready1, 1'b0);
    chk("rst_rvalid0", bus.rvalid0, 1'b0);
    chk("rst_rvalid1", bus.rvalid1, 1'b0);
    chk("rst_ram_we", bus.ram_we, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);

    // Read arbitration: port 0 wins the first tie.
    @(negedge clk); reset = 1'b0; #1;
    chk("arb_t_ready0", bus.ready0, 1'b1);
    chk("arb_t_ready1", bus.ready1, 1'b0);
    chk("arb_t_ram_ad", bus.ram_ad, 32'h10);
    chk("arb_t_ram_we", bus.ram_we, 1'b0);
    @(negedge clk); bus.req0 = 1'b0; #1;
    chk("arb_t1_rvalid0", bus.rvalid0, 1'b1);
    chk("arb_t1_rvalid1", bus.rvalid1, 1'b0);
    chk("arb_t1_rdata0", bus.rdata0, 32'h1111_1111);
    chk("arb_t1_ready1", bus.ready1, 1'b0);
    chk("arb_t1_busy", bus.busy, 1'b1);
    chk("arb_t1_ram_ad", bus.ram_ad, 32'h0);
    @(negedge clk); #1;
    chk("arb_t2_ready1", bus.ready1, 1'b1);
    chk("arb_t2_ram_ad", bus.ram_ad, 32'h20);
    @(negedge clk); bus.req1 = 1'b0; #1;
    chk("arb_t3_rvalid1", bus.rvalid1, 1'b1);
    chk("arb_t3_rvalid0", bus.rvalid0, 1'b0);
    chk("arb_t3_rdata1", bus.rdata1, 32'h2222_2222);

    // Full write then readback.
    @(negedge clk); port0(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF); #1;
    chk("fw_ready0", bus.ready0, 1'b1);
    chk("fw_ram_we", bus.ram_we, 1'b1);
    chk("fw_ram_d", bus.ram_d, 32'hDEAD_BEEF);
    chk("fw_ram_ad", bus.ram_ad, 32'h40);
    @(negedge clk); port0(1'b1, 1'b0, 32'h40, 32'h0, 4'hF); #1;
    chk("fw_busy", bus.busy, 1'b0);
    chk("fw_rd_ready0", bus.ready0, 1'b1);
    chk("fw_rd_ram_we", bus.ram_we, 1'b0);
    @(negedge clk); bus.req0 = 1'b0; #1;
    chk("fw_rvalid0", bus.rvalid0, 1'b1);
    chk("fw_rdata0", bus.rdata0, 32'hDEAD_BEEF);

    // Byte merge on port 1.
    @(negedge clk); port1(1'b1, 1'b1, 32'h40, 32'h0000_00AA, 4'h1); #1;
    chk("bm_t_ready1", bus.ready1, 1'b1);
    chk("bm_t_ram_we", bus.ram_we, 1'b0);
    chk("bm_t_ram_ad", bus.ram_ad, 32'h40);
    @(negedge clk); bus.req1 = 1'b0; #1;
    chk("bm_t1_ram_we", bus.ram_we, 1'b1);
    chk("bm_t1_ram_d", bus.ram_d, 32'hDEAD_BEAA);
    chk("bm_t1_ram_ad", bus.ram_ad, 32'h40);
    chk("bm_t1_busy", bus.busy, 1'b1);
    chk("bm_t1_ready1", bus.ready1, 1'b0);
    @(negedge clk); port1(1'b1, 1'b0, 32'h40, 32'h0, 4'hF); #1;
    chk("bm_rd_ready1", bus.ready1, 1'b1);
    @(negedge clk); bus.req1 = 1'b0; #1;
    chk("bm_rvalid1", bus.rvalid1, 1'b1);
    chk("bm_rdata1", bus.rdata1, 32'hDEAD_BEAA);

    // Empty byte enable: acknowledged, RAM untouched.
    @(negedge clk); port0(1'b1, 1'b1, 32'h40, 32'h1234_5678, 4'h0); #1;
    chk("be0_ready0", bus.ready0, 1'b1);
    chk("be0_ram_we", bus.ram_we, 1'b0);
    @(negedge clk); port0(1'b1, 1'b0, 32'h40, 32'h0, 4'hF); #1;
    chk("be0_busy", bus.busy, 1'b0);
    chk("be0_rd_ready0", bus.ready0, 1'b1);
    chk("be0_rd_ram_we", bus.ram_we, 1'b0);
    @(negedge clk); bus.req0 = 1'b0; #1;
    chk("be0_rvalid0", bus.rvalid0, 1'b1);
    chk("be0_rdata0", bus.rdata0, 32'hDEAD_BEAA);

    // Reset during RMW aborts the write.
    @(negedge clk); port1(1'b1, 1'b1, 32'h40, 32'h0000_5500, 4'h2); #1;
    chk("ra_ready1", bus.ready1, 1'b1);
    @(negedge clk); bus.req1 = 1'b0; reset = 1'b1; #1;
    chk("ra_rmw_ram_we", bus.ram_we, 1'b0);
    chk("ra_rmw_busy", bus.busy, 1'b0);
    chk("ra_rmw_ready1", bus.ready1, 1'b0);
    @(negedge clk); reset = 1'b0; #1;
    chk("ra_next_busy", bus.busy, 1'b0);
    chk("ra_next_ram_we", bus.ram_we, 1'b0);
    @(negedge clk); port1(1'b1, 1'b0, 32'h40, 32'h0, 4'hF); #1;
    chk("ra_rd_ready1", bus.ready1, 1'b1);
    @(negedge clk); bus.req1 = 1'b0; #1;
    chk("ra_rvalid1", bus.rvalid1, 1'b1);
    chk("ra_rdata1", bus.rdata1, 32'hDEAD_BEAA);

    // Fairness: both ports hold full-write requests; grants alternate from port 0.
    @(negedge clk);
    port0(1'b1, 1'b1, 32'h80, 32'hA0A0_A0A0, 4'hF);
    port1(1'b1, 1'b1, 32'h84, 32'hB1B1_B1B1, 4'hF);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk($sformatf("fair%0d_ready0", i), bus.ready0, (i % 2 == 0) ? 1'b1 : 1'b0);
      chk($sformatf("fair%0d_ready1", i), bus.ready1, (i % 2 == 1) ? 1'b1 : 1'b0);
    end

    // Quiet bus: no RAM access drives zeros.
    @(negedge clk); bus.req0 = 1'b0; bus.req1 = 1'b0; #1;
    chk("idle_ram_ad", bus.ram_ad, 32'h0);
    chk("idle_ram_d", bus.ram_d, 32'h0);
    chk("idle_ram_we", bus.ram_we, 1'b0);
    chk("mem_80", mem[32], 32'hA0A0_A0A0);
    chk("mem_84", mem[33], 32'hB1B1_B1B1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter WORD, default 4, bytes per word.
REQ-002 SHALL have parameter WIDTH, default 8, bits per byte.
REQ-003 SHALL have parameter ADDR_WIDTH, default 10, RAM byte-address bits; carried for the RAM instance only, no effect on arbiter logic.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports reqN  input  1  request, N in {0,1}; port 0 is CPU data, port 1 is loader/debug.
REQ-007 SHALL have ports weN  input  1  1 = write, 0 = read.
REQ-008 SHALL have ports addrN  input  WORD*WIDTH  byte address.
REQ-009 SHALL have ports wdataN  input  WORD*WIDTH  write data.
REQ-010 SHALL have ports beN  input  WORD  byte enables; be[i] covers bits [WIDTH*i+WIDTH-1 : WIDTH*i].
REQ-011 SHALL have ports readyN  output  1  request accepted this cycle.
REQ-012 SHALL have ports rvalidN  output  1  read data valid this cycle.
REQ-013 SHALL have ports rdataN  output  WORD*WIDTH  read data.
REQ-014 SHALL have port ram_d  output  WORD*WIDTH  to RAM data in.
REQ-015 SHALL have port ram_ad  output  WORD*WIDTH  to RAM address.
REQ-016 SHALL have port ram_we  output  1  to RAM write enable.
REQ-017 SHALL have port ram_q  input  WORD*WIDTH  from RAM; registered read, contents of ram_ad valid the cycle after ram_ad is presented; a write cycle returns old contents.
REQ-018 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, RD_WAIT, RMW.
- IDLE: accepts at most one request per cycle.
- RD_WAIT: one cycle, returns read data.
- RMW: one cycle, merge-write.
REQ-020 SHALL arbitrate in IDLE round-robin.
- Single requester wins.
- If both request, grant goes to the port not granted last.
- last_grant updates only on acceptance.
REQ-021 SHALL assert readyN combinationally, for one cycle, only in IDLE, only for the winner, only when reqN=1 and reset=0.
REQ-022 SHALL drive ram_ad=addrN of the winner in the accept cycle.
REQ-023 SHALL accept a read by driving ram_we=0 and going IDLE->RD_WAIT.
- In RD_WAIT: rvalidN=1 for the winning port, rdataN=ram_q, ram_we=0, next state IDLE.
- Read latency: rvalid 1 cycle after ready.
REQ-024 SHALL accept a full write (be all ones) by driving ram_we=1 and ram_d=wdata in the same cycle, remaining in IDLE; no rvalid.
REQ-025 SHALL accept a partial write (be not all-zero, not all-ones) as follows:
- Accept cycle: ram_we=0; latch addr, wdata, be; go to RMW.
- RMW cycle: ram_ad=latched addr, ram_we=1, ram_d byte i = be[i] ? wdata byte i : ram_q byte i; next state IDLE.
REQ-026 SHALL accept a write with be=0 as a no-op: ready pulses, ram_we=0, stays IDLE.
REQ-027 SHALL ignore beN for reads; the full word is returned.
REQ-028 SHALL keep readyN=0 in RD_WAIT and RMW; requesters hold req/addr/data until ready.
REQ-029 SHALL pass addresses unmodified (no alignment check); the RAM truncates to ADDR_WIDTH.
REQ-030 SHALL leave rdataN = ram_q at all times, meaningful only while rvalidN=1.
REQ-031 SHALL assert rvalid only to the port that issued the read; the other port's rvalid stays 0.
REQ-032 SHALL drive ram_d=0 and ram_ad=0 in cycles with no RAM access.

Reset
REQ-033 SHALL, on reset=1 at a clock edge, set state=IDLE and last_grant=1 (port 0 wins the first tie).
REQ-034 SHALL hold, while reset=1: ready0/1=0, rvalid0/1=0, ram_we=0, busy=0.
REQ-035 SHALL, on reset during RD_WAIT or RMW, abort the operation: no rvalid, no RAM write; the request is lost.

Verification
REQ-036 SHALL cover, each as stimulus -> required response:
- Read arbitration: after reset, req0 and req1 both reading, addr0=0x10, addr1=0x20 -> ready0 at T, rvalid0 at T+1; ready1 at T+2, rvalid1 at T+3.
- Full write: port0 write addr=0x40, wdata=0xDEADBEEF, be=0xF -> ram_we=1 with ram_d=0xDEADBEEF in the ready cycle; a later read returns 0xDEADBEEF.
- Byte merge: word at 0x40=0xDEADBEEF; port1 write wdata=0x000000AA, be=0x1 -> ram_we=0 at T, ram_we=1 with ram_d=0xDEADBEAA at T+1; readback 0xDEADBEAA.
- Empty enable: be=0 write -> ready pulse, ram_we never asserted, memory unchanged.
- Reset abort: reset high during RMW cycle -> ram_we=0, busy=0 next cycle; memory unchanged.
- Fairness: both ports requesting continuously for 8 accepts -> grants alternate 0,1,0,1,...
